// File: rtl/s2p_frame_fifo.sv
// Multi-channel frame-synced serial-to-parallel converter with an output FIFO.
// Optional sticky overrun flag and drop counter: define S2P_OVERRUN_STATUS_EN.
module s2p_frame_fifo #(
    parameter int WIDTH     = 16,
    parameter int NCH       = 2,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                         DCLK,
    input  logic                         clear,
    input  logic                         InReady,
    input  logic                         Frame,
    input  logic [NCH-1:0]               SerialIn,
    output logic [NCH*WIDTH-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         frame_err
`ifdef S2P_OVERRUN_STATUS_EN
    ,
    output logic                         overrun,
    output logic [7:0]                   ovr_cnt
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_d;
    logic [CW-1:0] bit_cnt, cnt_d;
    logic load, push, err_d;

    logic [NCH-1:0][WIDTH-1:0] shreg, shnext;
    logic [NCH*WIDTH-1:0] push_word;

    logic [NCH*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic full, do_pop, do_write, drop;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            always_comb begin
                for (int k = 0; k < NCH; k++)
                    shnext[k] = {shreg[k][WIDTH-2:0], SerialIn[k]};
            end
        end else begin : g_lsb
            always_comb begin
                for (int k = 0; k < NCH; k++)
                    shnext[k] = {SerialIn[k], shreg[k][WIDTH-1:1]};
            end
        end
    endgenerate

    assign push_word = shnext;

    always_comb begin
        state_d = state;
        cnt_d   = bit_cnt;
        load    = 1'b0;
        push    = 1'b0;
        err_d   = 1'b0;
        if (InReady) begin
            unique case (state)
                IDLE: begin
                    if (Frame) begin
                        load    = 1'b1;
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    load = 1'b1;
                    // A frame pulse anywhere inside a word, including its last bit, restarts capture
                    if (Frame) begin
                        err_d = 1'b1;
                        cnt_d = CW'(1);
                    end else if (bit_cnt == LAST) begin
                        push    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = bit_cnt + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge DCLK) begin
        if (clear) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= cnt_d;
            frame_err <= err_d;
            if (load)
                shreg <= shnext;
        end
    end

    assign out_valid = (fill != '0);
    assign full      = (fill == FW'(DEPTH));
    assign do_pop    = out_valid && out_ready;
    assign do_write  = push && (!full || do_pop);
    assign drop      = push && full && !do_pop;

    always_ff @(posedge DCLK) begin
        if (do_write)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge DCLK) begin
        if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            out_data <= '0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_write && !do_pop)
                fill <= fill + FW'(1);
            else if (do_pop && !do_write)
                fill <= fill - FW'(1);
            // out_data tracks the head as it will be after this edge
            if (do_pop) begin
                if (fill > FW'(1))
                    out_data <= mem[rd_ptr + AW'(1)];
                else if (do_write)
                    out_data <= push_word;
            end else if (do_write && fill == '0) begin
                out_data <= push_word;
            end
        end
    end

`ifdef S2P_OVERRUN_STATUS_EN
    always_ff @(posedge DCLK) begin
        if (clear) begin
            overrun <= 1'b0;
            ovr_cnt <= '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (ovr_cnt != 8'hFF)
                ovr_cnt <= ovr_cnt + 8'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule
